// File: rtl/syn_fifo_pkg.sv
// Shared width helpers and the wrapping pointer increment for syn_fifo.
package syn_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap explicitly at depth-1 so non-power-of-two depths stay in range.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// Storage for syn_fifo: synchronous write, registered read, storage not reset.
// Latency: read data appears the cycle after re_i. No flow control of its own; the caller gates we_i/re_i.
// Same-address read and write in one cycle returns the old contents.
module syn_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; stale storage is never observable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/syn_fifo.sv
// Single-clock FIFO with occupancy count, almost flags and optional sticky errors (SYN_FIFO_ERR_EN).
// Latency: flags/count follow the accepting edge; rd_data/rd_valid one cycle after rd_en is accepted.
// Backpressure: writes dropped when full unless a read frees a slot; reads dropped when empty.
module syn_fifo
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count
`ifdef SYN_FIFO_ERR_EN
    ,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_TH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;

    logic full_s;
    logic empty_s;
    logic wr_acc;
    logic rd_acc;

    assign full_s  = (count_q == FULL_CNT);
    assign empty_s = (count_q == '0);

    // A full FIFO still takes a write when a read frees the oldest slot this edge.
    assign wr_acc = wr_en && (!full_s || rd_en);
    assign rd_acc = rd_en && !empty_s;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (rd_acc) begin
            rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    syn_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);

`ifdef SYN_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (wr_en && !wr_acc);
        underflow_d = underflow_q | (rd_en && empty_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
